mem_load_ctrl: RTL and testbench
================================

# mem_load_ctrl

Boot/load sequencer and data-memory port arbiter for the single-cycle RISC-V CPU top. Holds `riscv_cpu` in reset while a host streams (address, word) pairs into `data_mem`, then releases the CPU after a fixed settle delay. It muxes the memory write port between the host loader and the CPU. A host re-load can be requested at any time while the CPU runs; this re-asserts CPU reset and takes the port back.

## Interface
- `HOLD_CYCLES`, default 4: cycles between the last accepted beat and CPU release; legal range ≥1.
- `CNT_W`, default 16: width of `words_loaded`.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `ld_start` in 1: single-cycle request to (re)enter load mode; honoured only in RUN.
- `ld_valid` in 1: host beat valid.
- `ld_ready` out 1: beat accepted on an edge where `ld_valid && ld_ready`.
- `ld_addr` in 32: byte address of the beat.
- `ld_data` in 32: word to store.
- `ld_last` in 1: marks the final beat of a load.
- `cpu_MemWrite` in 1: CPU store strobe.
- `cpu_DataAdr` in 32: CPU data address.
- `cpu_WriteData` in 32: CPU store data.
- `cpu_MemSel` in 3: CPU store size code.
- `cpu_reset` out 1: reset to `riscv_cpu`.
- `mem_MemWrite` out 1: write strobe to `data_mem`.
- `mem_DataAdr` out 32: address to `data_mem`.
- `mem_WriteData` out 32: write data to `data_mem`.
- `mem_Store` out 3: store size code to `data_mem`.
- `busy` out 1: high in LOAD and HOLD.
- `err` out 1: sticky misaligned-beat flag.
- `words_loaded` out CNT_W: words written since the last load start.

## Operation
- States: LOAD, HOLD, RUN.
  - Reset enters LOAD.
  - LOAD goes to HOLD on an accepted beat with `ld_last=1`.
  - HOLD goes to RUN after HOLD_CYCLES edges.
  - RUN goes to LOAD on `ld_start`.
  - No other transitions.
- `ld_ready` = 1 exactly in LOAD.
  - The beat register drains every cycle, so no backpressure is needed inside LOAD.
- Accepted beat handling:
  - Each accepted beat is latched into a one-deep beat register (addr, data, pending).
  - If `ld_addr[1:0]==0`, pending is set and `words_loaded` increments, saturating at all-ones.
  - If `ld_addr[1:0]!=0`, the beat is dropped (no write), `err` is set, and there is no count.
  - `ld_last` on a misaligned beat still ends the load.
- Port mux:
  - LOAD/HOLD: `mem_MemWrite` = pending, `mem_DataAdr` = latched addr, `mem_WriteData` = latched data, `mem_Store` = STORE_WORD (3'b010).
  - LOAD/HOLD: CPU store signals are ignored entirely.
  - RUN: all four `mem_*` outputs pass `cpu_*` combinationally.
- `cpu_reset` = 1 in LOAD and HOLD, 0 in RUN; driven from the state register, glitch-free.
- `ld_start` in RUN clears `err` and `words_loaded` on the transition edge. `ld_start` in LOAD/HOLD is ignored.
- Reset values:
  - state LOAD
  - `cpu_reset`=1, `ld_ready`=1, `busy`=1
  - pending=0, so `mem_MemWrite`=0
  - `mem_DataAdr`=0, `mem_WriteData`=0, `mem_Store`=3'b010
  - `err`=0, `words_loaded`=0, hold counter 0

## Timing
- Beat accepted at edge k: `data_mem` write occurs in cycle k+1 (strobe high for exactly one cycle unless another beat was accepted at k+1).
- `ld_last` accepted at edge k:
  - HOLD is entered at k.
  - The final write completes in cycle k+1.
  - RUN is entered at edge k+HOLD_CYCLES, so `cpu_reset` falls there.
  - With HOLD_CYCLES=1, the last write (cycle k+1) still precedes the first CPU cycle.
- Back-to-back beats sustain one write per cycle.
- `ld_start` sampled at edge m in RUN:
  - `cpu_reset`=1 and the port switches to the loader from m.
  - A CPU store in cycle m-1 completes; none is issued afterwards.
- Asynchronous `reset` mid-load or mid-hold:
  - Pending write is discarded, counters cleared, state LOAD.
  - `cpu_reset` asserts with no clock.

## Structure
- Shared package `rv_soc_pkg`:
  - state enum (LOAD/HOLD/RUN)
  - `STORE_WORD` = 3'b010
  - `XLEN` = 32
- No sub-module: state register, hold counter, beat register and mux stay in one module.
- Instantiated in the CPU top between host loader, `riscv_cpu` reset and `data_mem` port.

## Test plan
- Reset, then beats (0x0,0x11111111),(0x4,0x22222222),(0x8,0x33333333, last):
  - three writes in consecutive cycles
  - `words_loaded`=3
  - `cpu_reset` falls exactly 4 edges after the last-beat edge.
- Beat at 0x6 then last beat at 0xC:
  - no write to 0x6, `err`=1, `words_loaded`=1
  - RUN still reached
  - next `ld_start` clears `err`.
- In RUN, CPU stores 0xDEADBEEF to 0x20 with MemSel=3'b000: `mem_*` equals `cpu_*` the same cycle.
- `ld_start` during a CPU store burst:
  - from the next edge `cpu_reset`=1 and `mem_MemWrite` follows only loader beats
  - CPU stores are blocked.
- `reset` asserted mid-HOLD with a beat pending:
  - outputs return to reset values asynchronously
  - no write issued
  - state LOAD.
- HOLD_CYCLES=1 with a single last beat: write in cycle k+1, RUN at edge k+1.

Source files
------------

// File: rtl/rv_soc_pkg.sv
// -----------------------------------------------------------------------------
// rv_soc_pkg
// Shared definitions for the single-cycle RISC-V SoC slice:
//   state_t      - load sequencer states (LOAD / HOLD / RUN)
//   STORE_WORD   - data_mem store size code for a full 32-bit word
//   XLEN         - datapath width
//   word_aligned - true when a byte address points at a word boundary
// -----------------------------------------------------------------------------
package rv_soc_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] STORE_WORD = 3'b010;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   function automatic logic word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage : rv_soc_pkg

// File: rtl/mem_load_ctrl.sv
// -----------------------------------------------------------------------------
// mem_load_ctrl
// Boot/load sequencer and data-memory write-port arbiter.
// Holds the CPU in reset while a host streams (address, word) beats into
// data_mem, releases it HOLD_CYCLES edges after the last beat, and lets the
// host re-enter load mode at any time while the CPU runs.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   ld_start          - request to re-enter load mode (honoured in RUN only)
//   ld_valid/ld_ready - host beat handshake (ready exactly in LOAD)
//   ld_addr, ld_data  - beat byte address and word
//   ld_last           - final beat of a load
//   cpu_MemWrite, cpu_DataAdr, cpu_WriteData, cpu_MemSel - CPU store port
//   cpu_reset         - reset to riscv_cpu (high in LOAD/HOLD)
//   mem_MemWrite, mem_DataAdr, mem_WriteData, mem_Store  - data_mem port
//   busy              - high in LOAD and HOLD
//   err               - sticky misaligned-beat flag
//   words_loaded      - saturating count of words written since load start
// -----------------------------------------------------------------------------
module mem_load_ctrl
   import rv_soc_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_start,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [XLEN-1:0]  ld_addr,
   input  logic [XLEN-1:0]  ld_data,
   input  logic             ld_last,
   input  logic             cpu_MemWrite,
   input  logic [XLEN-1:0]  cpu_DataAdr,
   input  logic [XLEN-1:0]  cpu_WriteData,
   input  logic [2:0]       cpu_MemSel,
   output logic             cpu_reset,
   output logic             mem_MemWrite,
   output logic [XLEN-1:0]  mem_DataAdr,
   output logic [XLEN-1:0]  mem_WriteData,
   output logic [2:0]       mem_Store,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] words_loaded
);

   // Hold counter runs 0 .. HOLD_CYCLES-1; RUN is entered on the edge
   // where it has reached the last value.
   localparam int              HC_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            r_state;
   state_t            w_next_state;
   logic              r_cpu_reset;
   logic [HC_W-1:0]   r_hold_cnt;
   logic              r_pend;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_data;
   logic              r_err;
   logic [CNT_W-1:0]  r_words;

   logic              w_accept;
   logic              w_aligned;
   logic              w_hold_done;
   logic              w_restart;

   assign w_accept    = ld_valid && (r_state == ST_LOAD);
   assign w_aligned   = word_aligned(ld_addr);
   assign w_hold_done = (r_state == ST_HOLD) && (r_hold_cnt == HC_LAST);
   assign w_restart   = (r_state == ST_RUN) && ld_start;

   // State register; cpu_reset is a flop of its own so it cannot glitch
   // while the encoded state bits change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_LOAD;
         r_cpu_reset <= 1'b1;
      end else begin
         r_state     <= w_next_state;
         r_cpu_reset <= (w_next_state != ST_RUN);
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_LOAD: begin
            // ld_last ends the load even when the beat itself is dropped.
            if (w_accept && ld_last) begin
               w_next_state = ST_HOLD;
            end else begin
               w_next_state = ST_LOAD;
            end
         end
         ST_HOLD: begin
            if (w_hold_done) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_HOLD;
            end
         end
         ST_RUN: begin
            if (ld_start) begin
               w_next_state = ST_LOAD;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         default: begin
            w_next_state = ST_LOAD;
         end
      endcase
   end

   // Hold counter: counts edges spent in HOLD, idle at zero elsewhere.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_cnt <= '0;
      end else if ((r_state == ST_HOLD) && !w_hold_done) begin
         r_hold_cnt <= r_hold_cnt + HC_W'(1);
      end else begin
         r_hold_cnt <= '0;
      end
   end

   // One-deep beat register; pending drains every cycle so a beat is
   // written exactly once, in the cycle after it was accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_pend <= w_accept && w_aligned;
         if (w_accept) begin
            r_addr <= ld_addr;
            r_data <= ld_data;
         end else begin
            r_addr <= r_addr;
            r_data <= r_data;
         end
      end
   end

   // Load statistics: sticky misalignment flag and saturating word count,
   // both cleared when a new load is started from RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err   <= 1'b0;
         r_words <= '0;
      end else if (w_restart) begin
         r_err   <= 1'b0;
         r_words <= '0;
      end else if (w_accept) begin
         if (w_aligned) begin
            if (r_words != CNT_MAX) begin
               r_words <= r_words + CNT_W'(1);
            end else begin
               r_words <= r_words;
            end
         end else begin
            r_err <= 1'b1;
         end
      end else begin
         r_err   <= r_err;
         r_words <= r_words;
      end
   end

   // Output decode and data_mem port mux. In RUN the CPU owns the port
   // combinationally; otherwise only the beat register can write.
   always_comb begin
      ld_ready      = (r_state == ST_LOAD);
      mem_MemWrite  = r_pend;
      mem_DataAdr   = r_addr;
      mem_WriteData = r_data;
      mem_Store     = STORE_WORD;
      if (r_state == ST_RUN) begin
         mem_MemWrite  = cpu_MemWrite;
         mem_DataAdr   = cpu_DataAdr;
         mem_WriteData = cpu_WriteData;
         mem_Store     = cpu_MemSel;
      end else begin
         mem_MemWrite  = r_pend;
         mem_DataAdr   = r_addr;
         mem_WriteData = r_data;
         mem_Store     = STORE_WORD;
      end
   end

   assign cpu_reset    = r_cpu_reset;
   assign busy         = r_cpu_reset;
   assign err          = r_err;
   assign words_loaded = r_words;

endmodule : mem_load_ctrl

// File: tb/tb_mem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_load_ctrl
// Self-checking bench for mem_load_ctrl. A behavioural model tracks the
// phase (load / hold / run), the write expected in the current cycle and the
// load statistics; scenario tasks compare DUT outputs against it and against
// fixed expectations. A second instance with HOLD_CYCLES=1 covers the
// shortest release delay.
// -----------------------------------------------------------------------------
module tb_mem_load_ctrl;

   localparam int HC = 4;
   localparam int CW = 16;
   localparam int PH_LOAD = 0;
   localparam int PH_HOLD = 1;
   localparam int PH_RUN  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        reset1;
   logic        ld_start, ld_valid, ld_last;
   logic [31:0] ld_addr, ld_data;
   logic        cpu_MemWrite;
   logic [31:0] cpu_DataAdr, cpu_WriteData;
   logic [2:0]  cpu_MemSel;

   logic        ld_ready, cpu_reset, mem_MemWrite, busy, err;
   logic [31:0] mem_DataAdr, mem_WriteData;
   logic [2:0]  mem_Store;
   logic [CW-1:0] words_loaded;

   logic        h1_ld_ready, h1_cpu_reset, h1_mem_MemWrite, h1_busy, h1_err;
   logic [31:0] h1_mem_DataAdr, h1_mem_WriteData;
   logic [2:0]  h1_mem_Store;
   logic [CW-1:0] h1_words_loaded;

   int errors = 0;
   int checks = 0;

   // model state
   int          m_phase;
   int          m_hold;
   bit          m_wr;
   logic [31:0] m_wa, m_wd;
   bit          m_err;
   int          m_words;

   always #5 clk = ~clk;

   mem_load_ctrl #(.HOLD_CYCLES(HC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
      .cpu_MemWrite(cpu_MemWrite), .cpu_DataAdr(cpu_DataAdr),
      .cpu_WriteData(cpu_WriteData), .cpu_MemSel(cpu_MemSel),
      .cpu_reset(cpu_reset), .mem_MemWrite(mem_MemWrite), .mem_DataAdr(mem_DataAdr),
      .mem_WriteData(mem_WriteData), .mem_Store(mem_Store), .busy(busy),
      .err(err), .words_loaded(words_loaded)
   );

   mem_load_ctrl #(.HOLD_CYCLES(1), .CNT_W(CW)) dut1 (
      .clk(clk), .reset(reset1), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_ready(h1_ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
      .cpu_MemWrite(cpu_MemWrite), .cpu_DataAdr(cpu_DataAdr),
      .cpu_WriteData(cpu_WriteData), .cpu_MemSel(cpu_MemSel),
      .cpu_reset(h1_cpu_reset), .mem_MemWrite(h1_mem_MemWrite), .mem_DataAdr(h1_mem_DataAdr),
      .mem_WriteData(h1_mem_WriteData), .mem_Store(h1_mem_Store), .busy(h1_busy),
      .err(h1_err), .words_loaded(h1_words_loaded)
   );

   task automatic model_reset();
      m_phase = PH_LOAD; m_hold = 0; m_wr = 0; m_wa = 0; m_wd = 0; m_err = 0; m_words = 0;
   endtask

   // Advance the model by one rising edge using the inputs present there.
   task automatic model_edge();
      bit wr_n = 0;
      case (m_phase)
         PH_LOAD: begin
            if (ld_valid) begin
               if ((ld_addr % 4) == 0) begin
                  wr_n = 1; m_wa = ld_addr; m_wd = ld_data;
                  if (m_words < (1 << CW) - 1) m_words++;
               end else begin
                  m_err = 1;
               end
               if (ld_last) begin m_phase = PH_HOLD; m_hold = HC; end
            end
         end
         PH_HOLD: begin
            m_hold--;
            if (m_hold == 0) m_phase = PH_RUN;
         end
         PH_RUN: begin
            if (ld_start) begin m_phase = PH_LOAD; m_err = 0; m_words = 0; end
         end
         default: ;
      endcase
      m_wr = wr_n;
   endtask

   function automatic logic e_cpu_reset();
      return (m_phase != PH_RUN);
   endfunction
   function automatic logic e_memwrite();
      return (m_phase == PH_RUN) ? cpu_MemWrite : m_wr;
   endfunction
   function automatic logic [31:0] e_adr();
      return (m_phase == PH_RUN) ? cpu_DataAdr : m_wa;
   endfunction
   function automatic logic [31:0] e_wdata();
      return (m_phase == PH_RUN) ? cpu_WriteData : m_wd;
   endfunction
   function automatic logic [2:0] e_store();
      return (m_phase == PH_RUN) ? cpu_MemSel : 3'b010;
   endfunction

   // One clock: rising edge (model follows), then settle to the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ld_start = 0; ld_valid = 0; ld_last = 0; ld_addr = 0; ld_data = 0;
      cpu_MemWrite = 0; cpu_DataAdr = 0; cpu_WriteData = 0; cpu_MemSel = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; reset1 = 1;
      #2;
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready got %b exp 1", ld_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
      checks++; if (mem_MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite got %b exp 0", mem_MemWrite); end
      checks++; if (mem_DataAdr !== 32'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", mem_DataAdr); end
      checks++; if (mem_WriteData !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_WriteData); end
      checks++; if (mem_Store !== 3'b010) begin errors++; $display("FAIL rst_store got %b exp 010", mem_Store); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL rst_words got %0d exp 0", words_loaded); end
      @(negedge clk);
      reset = 0;
      model_reset();
   endtask

   task automatic test_basic_load();
      logic [31:0] a [3];
      logic [31:0] d [3];
      int n;
      a[0] = 32'h0; a[1] = 32'h4; a[2] = 32'h8;
      d[0] = 32'h1111_1111; d[1] = 32'h2222_2222; d[2] = 32'h3333_3333;
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1; ld_addr = a[i]; ld_data = d[i]; ld_last = (i == 2);
         tick();
         checks++; if (mem_MemWrite !== 1'b1) begin errors++; $display("FAIL basic_wr%0d got %b exp 1", i, mem_MemWrite); end
         checks++; if (mem_DataAdr !== a[i]) begin errors++; $display("FAIL basic_adr%0d got %h exp %h", i, mem_DataAdr, a[i]); end
         checks++; if (mem_WriteData !== d[i]) begin errors++; $display("FAIL basic_data%0d got %h exp %h", i, mem_WriteData, d[i]); end
         checks++; if (mem_Store !== 3'b010) begin errors++; $display("FAIL basic_store%0d got %b exp 010", i, mem_Store); end
      end
      idle_inputs();
      checks++; if (words_loaded !== 16'd3) begin errors++; $display("FAIL basic_words got %0d exp 3", words_loaded); end
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_hold got %b exp 0", ld_ready); end
      n = 0;
      while (cpu_reset === 1'b1 && n < 20) begin
         tick(); n++;
         if (n == 1) begin
            checks++; if (mem_MemWrite !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", mem_MemWrite); end
         end
      end
      checks++; if (n != HC) begin errors++; $display("FAIL basic_release_edges got %0d exp %0d", n, HC); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_run got %b exp 0", busy); end
   endtask

   task automatic test_misaligned();
      int n;
      ld_start = 1; tick(); ld_start = 0;
      checks++; if (cpu_reset !== 1'b1 || words_loaded !== 16'd0) begin errors++; $display("FAIL mis_restart got rst %b words %0d exp 1 0", cpu_reset, words_loaded); end
      ld_valid = 1; ld_addr = 32'h6; ld_data = 32'hBAD0_0006; ld_last = 0;
      tick();
      checks++; if (mem_MemWrite !== 1'b0) begin errors++; $display("FAIL mis_nowrite got %b exp 0", mem_MemWrite); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", err); end
      ld_addr = 32'hC; ld_data = 32'h0C0C_0C0C; ld_last = 1;
      tick();
      idle_inputs();
      checks++; if (mem_MemWrite !== 1'b1 || mem_DataAdr !== 32'hC) begin errors++; $display("FAIL mis_last_wr got %b @%h exp 1 @0000000c", mem_MemWrite, mem_DataAdr); end
      checks++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL mis_words got %0d exp 1", words_loaded); end
      n = 0;
      while (cpu_reset === 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (cpu_reset !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL mis_run got rst %b err %b exp 0 1", cpu_reset, err); end
      ld_start = 1; tick(); ld_start = 0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b exp 0", err); end
   endtask

   // Load a single last beat from LOAD and wait for RUN (bounded).
   task automatic quick_load(input logic [31:0] a, input logic [31:0] d);
      int n;
      ld_valid = 1; ld_addr = a; ld_data = d; ld_last = 1;
      tick();
      idle_inputs();
      n = 0;
      while (m_phase != PH_RUN && n < 20) begin tick(); n++; end
   endtask

   task automatic test_cpu_passthrough();
      quick_load(32'h40, 32'h4040_4040);
      checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL pass_run got %b exp 0", cpu_reset); end
      cpu_MemWrite = 1; cpu_DataAdr = 32'h20; cpu_WriteData = 32'hDEAD_BEEF; cpu_MemSel = 3'b000;
      #1;
      checks++; if (mem_MemWrite !== 1'b1 || mem_DataAdr !== 32'h20 || mem_WriteData !== 32'hDEAD_BEEF || mem_Store !== 3'b000)
         begin errors++; $display("FAIL pass_store got %b %h %h %b exp 1 00000020 deadbeef 000", mem_MemWrite, mem_DataAdr, mem_WriteData, mem_Store); end
      for (int i = 0; i < 4; i++) begin
         cpu_MemWrite = 1'($urandom); cpu_DataAdr = $urandom; cpu_WriteData = $urandom; cpu_MemSel = 3'($urandom);
         tick();
         checks++; if (mem_MemWrite !== cpu_MemWrite || mem_DataAdr !== cpu_DataAdr || mem_WriteData !== cpu_WriteData || mem_Store !== cpu_MemSel)
            begin errors++; $display("FAIL pass_rand%0d got %b %h %h %b", i, mem_MemWrite, mem_DataAdr, mem_WriteData, mem_Store); end
      end
      idle_inputs();
   endtask

   task automatic test_ld_start_burst();
      int n;
      for (int i = 0; i < 10; i++) begin
         cpu_MemWrite = 1; cpu_DataAdr = {$urandom_range(0, 255), 2'b00}; cpu_WriteData = $urandom; cpu_MemSel = 3'($urandom);
         ld_start = (i == 3);
         ld_valid = (i >= 5) && (i % 2 == 1);
         ld_addr = 32'h100 + 32'(i * 4); ld_data = $urandom; ld_last = 0;
         tick();
         checks++; if (cpu_reset !== e_cpu_reset()) begin errors++; $display("FAIL burst_rst%0d got %b exp %b", i, cpu_reset, e_cpu_reset()); end
         checks++; if (mem_MemWrite !== e_memwrite()) begin errors++; $display("FAIL burst_wr%0d got %b exp %b", i, mem_MemWrite, e_memwrite()); end
         if (e_memwrite()) begin
            checks++; if (mem_DataAdr !== e_adr() || mem_WriteData !== e_wdata()) begin errors++; $display("FAIL burst_adr%0d got %h %h exp %h %h", i, mem_DataAdr, mem_WriteData, e_adr(), e_wdata()); end
         end
      end
      idle_inputs();
      quick_load(32'h200, 32'h0200_0200);
   endtask

   task automatic test_reset_mid_hold();
      ld_start = 1; tick(); ld_start = 0;
      ld_valid = 1; ld_addr = 32'h80; ld_data = 32'h8080_8080; ld_last = 1;
      @(posedge clk); model_edge(); #1;
      idle_inputs();
      checks++; if (mem_MemWrite !== 1'b1) begin errors++; $display("FAIL mh_pending got %b exp 1", mem_MemWrite); end
      reset = 1;
      #1;
      checks++; if (mem_MemWrite !== 1'b0 || mem_DataAdr !== 32'h0 || mem_WriteData !== 32'h0 || mem_Store !== 3'b010)
         begin errors++; $display("FAIL mh_port got %b %h %h %b exp 0 0 0 010", mem_MemWrite, mem_DataAdr, mem_WriteData, mem_Store); end
      checks++; if (cpu_reset !== 1'b1 || ld_ready !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || words_loaded !== 16'd0)
         begin errors++; $display("FAIL mh_ctrl got rst %b rdy %b busy %b err %b words %0d", cpu_reset, ld_ready, busy, err, words_loaded); end
      @(negedge clk);
      reset = 0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (mem_MemWrite !== 1'b0 || ld_ready !== 1'b1 || cpu_reset !== 1'b1)
            begin errors++; $display("FAIL mh_after%0d got wr %b rdy %b rst %b exp 0 1 1", i, mem_MemWrite, ld_ready, cpu_reset); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         ld_valid = ($urandom_range(0, 9) < 7);
         ld_addr  = {$urandom_range(0, 1023), 2'b00};
         if ($urandom_range(0, 5) == 0) ld_addr[1:0] = 2'($urandom_range(1, 3));
         ld_data  = $urandom;
         ld_last  = ($urandom_range(0, 9) == 0);
         ld_start = ($urandom_range(0, 14) == 0);
         cpu_MemWrite = 1'($urandom); cpu_DataAdr = $urandom; cpu_WriteData = $urandom; cpu_MemSel = 3'($urandom);
         tick();
         checks++; if (cpu_reset !== e_cpu_reset() || busy !== e_cpu_reset()) begin errors++; $display("FAIL rnd_rst%0d got %b/%b exp %b", i, cpu_reset, busy, e_cpu_reset()); end
         checks++; if (ld_ready !== (m_phase == PH_LOAD)) begin errors++; $display("FAIL rnd_ready%0d got %b exp %b", i, ld_ready, m_phase == PH_LOAD); end
         checks++; if (mem_MemWrite !== e_memwrite() || mem_Store !== e_store()) begin errors++; $display("FAIL rnd_wr%0d got %b %b exp %b %b", i, mem_MemWrite, mem_Store, e_memwrite(), e_store()); end
         if (e_memwrite()) begin
            checks++; if (mem_DataAdr !== e_adr() || mem_WriteData !== e_wdata()) begin errors++; $display("FAIL rnd_adr%0d got %h %h exp %h %h", i, mem_DataAdr, mem_WriteData, e_adr(), e_wdata()); end
         end
         checks++; if (err !== m_err || words_loaded !== 16'(m_words)) begin errors++; $display("FAIL rnd_stat%0d got err %b words %0d exp %b %0d", i, err, words_loaded, m_err, m_words); end
      end
      idle_inputs();
   endtask

   task automatic test_hold1();
      reset = 1; reset1 = 1;
      idle_inputs();
      @(negedge clk);
      reset = 0; reset1 = 0;
      model_reset();
      ld_valid = 1; ld_addr = 32'h10; ld_data = 32'hA5A5_0010; ld_last = 1;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      checks++; if (h1_mem_MemWrite !== 1'b1 || h1_mem_DataAdr !== 32'h10 || h1_mem_WriteData !== 32'hA5A5_0010)
         begin errors++; $display("FAIL h1_write got %b %h %h exp 1 00000010 a5a50010", h1_mem_MemWrite, h1_mem_DataAdr, h1_mem_WriteData); end
      checks++; if (h1_cpu_reset !== 1'b1) begin errors++; $display("FAIL h1_rst_k got %b exp 1", h1_cpu_reset); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (h1_cpu_reset !== 1'b0 || h1_busy !== 1'b0) begin errors++; $display("FAIL h1_run got rst %b busy %b exp 0 0", h1_cpu_reset, h1_busy); end
      checks++; if (h1_words_loaded !== 16'd1) begin errors++; $display("FAIL h1_words got %0d exp 1", h1_words_loaded); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_misaligned();
      test_cpu_passthrough();
      test_ld_start_burst();
      test_reset_mid_hold();
      test_random();
      test_hold1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_load_ctrl
